// File: rtl/uart_fifo_xcvr_if.sv
// Pin and user-side signal bundle of uart_fifo_xcvr; slave is the transceiver side,
// master is the user/board side.
interface uart_fifo_xcvr_if #(
  parameter int DATA_W = 8
);
  logic [2:0]        baud_select;
  logic [1:0]        parity_mode;
  logic              Tx_EN;
  logic              Tx_WR;
  logic [DATA_W-1:0] Tx_DATA;
  logic              Tx_BUSY;
  logic              TxD;
  logic              Rx_EN;
  logic              RxD;
  logic              Rx_RD;
  logic [DATA_W-1:0] Rx_DATA;
  logic              Rx_VALID;
  logic              Rx_FERROR;
  logic              Rx_PERROR;
  logic              Rx_OVERRUN;

  modport slave (
    input  baud_select, parity_mode, Tx_EN, Tx_WR, Tx_DATA, Rx_EN, RxD, Rx_RD,
    output Tx_BUSY, TxD, Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, Rx_OVERRUN
  );

  modport master (
    output baud_select, parity_mode, Tx_EN, Tx_WR, Tx_DATA, Rx_EN, RxD, Rx_RD,
    input  Tx_BUSY, TxD, Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, Rx_OVERRUN
  );
endinterface

// File: rtl/uart_fifo_xcvr.sv
// Full-duplex UART with runtime baud/parity, 16x oversampled receiver and FWFT receive FIFO.
// Define UART_LOOPBACK_EN to feed TxD straight into the receiver instead of the RxD pin.
module uart_fifo_xcvr #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  uart_fifo_xcvr_if.slave u
);

  // Rounded clocks-per-tick for each baud_select code.
  function automatic int div_of(input int sel);
    int rate;
    case (sel)
      0:       rate = 300;
      1:       rate = 1200;
      2:       rate = 4800;
      3:       rate = 9600;
      4:       rate = 19200;
      5:       rate = 38400;
      6:       rate = 57600;
      default: rate = 115200;
    endcase
    return (CLK_HZ + 8 * rate) / (16 * rate);
  endfunction

  localparam int CW = $clog2(16 * div_of(0) + 1);
  localparam int IW = $clog2(DATA_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;
  localparam int LEN_TAB [8] = '{16 * div_of(0), 16 * div_of(1), 16 * div_of(2), 16 * div_of(3),
                                 16 * div_of(4), 16 * div_of(5), 16 * div_of(6), 16 * div_of(7)};

  function automatic logic [CW-1:0] bit_len(input logic [2:0] sel);
    return CW'(LEN_TAB[sel]);
  endfunction

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;

  tx_state_t         tx_state;
  logic [CW-1:0]     tx_cnt, tx_len;
  logic [DATA_W-1:0] tx_shift;
  logic [IW-1:0]     tx_idx;
  logic              tx_par_en, tx_par_bit, tx_end;

  assign tx_end = (tx_cnt == tx_len - 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state   <= T_IDLE;
      tx_cnt     <= '0;
      tx_len     <= '0;
      tx_shift   <= '0;
      tx_idx     <= '0;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
      u.TxD      <= 1'b1;
      u.Tx_BUSY  <= 1'b0;
    end else if (tx_state == T_IDLE) begin
      if (u.Tx_WR && u.Tx_EN) begin
        tx_state   <= T_START;
        tx_cnt     <= '0;
        tx_len     <= bit_len(u.baud_select);
        tx_shift   <= u.Tx_DATA;
        tx_idx     <= '0;
        tx_par_en  <= ^u.parity_mode;
        tx_par_bit <= (^u.Tx_DATA) ^ u.parity_mode[1];
        u.TxD      <= 1'b0;
        u.Tx_BUSY  <= 1'b1;
      end
    end else if (!tx_end) begin
      tx_cnt <= tx_cnt + 1'b1;
    end else begin
      tx_cnt <= '0;
      case (tx_state)
        T_START: begin
          tx_state <= T_DATA;
          u.TxD    <= tx_shift[0];
        end
        T_DATA: begin
          if (tx_idx == IW'(DATA_W - 1)) begin
            tx_state <= tx_par_en ? T_PAR : T_STOP;
            u.TxD    <= tx_par_en ? tx_par_bit : 1'b1;
          end else begin
            tx_idx   <= tx_idx + 1'b1;
            tx_shift <= tx_shift >> 1;
            u.TxD    <= tx_shift[1];
          end
        end
        T_PAR: begin
          tx_state <= T_STOP;
          u.TxD    <= 1'b1;
        end
        default: begin
          tx_state  <= T_IDLE;
          u.Tx_BUSY <= 1'b0;
        end
      endcase
    end
  end

  logic rx_pin, rx_s1, rx_s2, rx_prev;
`ifdef UART_LOOPBACK_EN
  assign rx_pin = u.TxD;
`else
  assign rx_pin = u.RxD;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_pin;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  rx_state_t         rx_state;
  logic [CW-1:0]     rx_cnt, rx_len;
  logic [DATA_W-1:0] rx_shift;
  logic [IW-1:0]     rx_idx;
  logic              rx_par_en, rx_par_odd, rx_perr, rx_end, rx_stop_hit;
  logic [EW-1:0]     rx_entry;

  assign rx_end      = (rx_cnt == rx_len - 1'b1);
  assign rx_stop_hit = u.Rx_EN && (rx_state == R_STOP) && rx_end;
  assign rx_entry    = {rx_perr, ~rx_s2, rx_shift};

  // Only a high-to-low transition arms the receiver, so a stuck-low line after a
  // framing error cannot retrigger until it has gone high again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state   <= R_IDLE;
      rx_cnt     <= '0;
      rx_len     <= '0;
      rx_shift   <= '0;
      rx_idx     <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_perr    <= 1'b0;
    end else if (!u.Rx_EN) begin
      rx_state <= R_IDLE;
    end else begin
      case (rx_state)
        R_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state   <= R_START;
            rx_cnt     <= '0;
            rx_len     <= bit_len(u.baud_select);
            rx_idx     <= '0;
            rx_par_en  <= ^u.parity_mode;
            rx_par_odd <= u.parity_mode[1];
            rx_perr    <= 1'b0;
          end
        end
        R_START: begin
          if (rx_cnt == (rx_len >> 1) - 1'b1) begin
            rx_cnt   <= '0;
            rx_state <= rx_s2 ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (!rx_end) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt <= '0;
            case (rx_state)
              R_DATA: begin
                rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
                if (rx_idx == IW'(DATA_W - 1)) rx_state <= rx_par_en ? R_PAR : R_STOP;
                else                           rx_idx   <= rx_idx + 1'b1;
              end
              R_PAR: begin
                rx_perr  <= rx_s2 ^ (^rx_shift) ^ rx_par_odd;
                rx_state <= R_STOP;
              end
              default: rx_state <= R_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic          rx_valid, full, push, pop;

  assign rx_valid = (wr_ptr != rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = u.Rx_RD && rx_valid;
  assign push     = rx_stop_hit && (!full || pop);
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      u.Rx_OVERRUN <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop)                       u.Rx_OVERRUN <= 1'b0;
      else if (rx_stop_hit && full)  u.Rx_OVERRUN <= 1'b1;
    end
  end

  assign u.Rx_VALID  = rx_valid;
  assign u.Rx_DATA   = rx_valid ? head[DATA_W-1:0] : '0;
  assign u.Rx_FERROR = rx_valid & head[DATA_W];
  assign u.Rx_PERROR = rx_valid & head[DATA_W+1];

endmodule

// File: doc/uart_fifo_xcvr.md
# uart_fifo_xcvr

Parametrised full-duplex UART transceiver: the next generation of the fixed 8-bit, fixed-baud transmitter/receiver pair. It adds configurable data width, runtime parity mode, a baud divisor table derived from the clock frequency, and a first-word-fall-through receive FIFO with overrun detection. It sits between the board serial pins and user logic, and optionally loops TxD back to the receiver for self-test.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz
- DATA_W, 8, data bits per frame; legal range 5..9
- FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥2
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- baud_select  in  3  rate: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
- Tx_EN  in  1  transmitter enable
- Tx_WR  in  1  one-cycle write strobe
- Tx_DATA  in  DATA_W  byte to send, LSB first
- Tx_BUSY  out  1  frame in progress
- TxD  out  1  serial out, idle high
- Rx_EN  in  1  receiver enable
- RxD  in  1  serial in (asynchronous)
- Rx_RD  in  1  pop FIFO head
- Rx_DATA  out  DATA_W  FIFO head data
- Rx_VALID  out  1  FIFO not empty
- Rx_FERROR  out  1  head frame had stop bit = 0
- Rx_PERROR  out  1  head frame parity mismatch
- Rx_OVERRUN  out  1  sticky; frame dropped because FIFO full

## Operation
- Divisor: DIV = round(CLK_HZ / (16 × rate)), computed at elaboration (CLK_HZ=50 MHz, sel 7 → 27); 16× oversample; one bit = 16·DIV cycles.
- baud_select and parity_mode latched independently by Tx and Rx at frame start; changes mid-frame affect only the next frame.
- Tx FSM IDLE→START→DATA(DATA_W bits)→PARITY (skipped if none)→STOP→IDLE. Write accepted when Tx_WR & Tx_EN & !Tx_BUSY; Tx_DATA captured that cycle. Tx_WR while busy or with Tx_EN low is ignored. Tx_EN low mid-frame: the frame completes.
- Parity computed over DATA_W bits; even → parity bit = XOR of data, odd → its inverse.
- Rx: RxD passes a 2-flop synchronizer. Rx FSM IDLE→START→DATA→PARITY→STOP→IDLE. A falling edge in IDLE starts the tick counter; the line is re-sampled at tick 8 (start midpoint); high → false start, back to IDLE. Subsequent bits sampled every 16 ticks (bit midpoints).
- At the stop midpoint the entry {PERROR, FERROR, data} is pushed. FERROR = stop sampled 0; PERROR = parity mismatch (0 when parity none). Frames with errors are still pushed. After a stop bit of 0, Rx waits for the line to return high before re-arming.
- FIFO: FWFT; Rx_DATA/Rx_FERROR/Rx_PERROR show the head and are forced 0 when Rx_VALID=0. Rx_RD pops only when Rx_VALID; Rx_RD on empty is ignored.
- Push when full without a simultaneous pop: the frame is dropped and Rx_OVERRUN is set; it clears on the next accepted Rx_RD. A push and a pop in the same cycle when full are both accepted with no overrun.
- Rx_EN low: Rx FSM forced to IDLE; a frame in progress is aborted with no push; FIFO contents retained.
- Reset (async, any time): TxD=1, Tx_BUSY=0, Rx_VALID=0, Rx_DATA=0, Rx_FERROR=0, Rx_PERROR=0, Rx_OVERRUN=0; FIFO emptied; both FSMs in IDLE.

## Timing
- Tx_WR accepted at edge n → Tx_BUSY=1 and TxD=0 from n+1; the Tx divisor restarts at acceptance, so the start bit is exactly 16·DIV cycles.
- Tx frame length = (2 + DATA_W + P)·16·DIV cycles, P∈{0,1}; Tx_BUSY falls the cycle after the stop bit ends, and a new Tx_WR is accepted on that same cycle.
- Rx: the synchronizer adds 2 cycles; the push happens at the stop midpoint; Rx_VALID rises the cycle after the push.
- Rx_RD at edge n → next head (or Rx_VALID=0) visible at n+1.

## Configuration
- UART_LOOPBACK_EN defined: the receiver input is internally tied to TxD (pre-synchronizer), the RxD pin is ignored, and TxD is still driven to the pin.
- Undefined: the receiver uses RxD; there is no internal path from TxD.

## Test plan
- Loopback, sel 7, 8N1, write 0xA5 → Tx_BUSY high for 4320 cycles; Rx_VALID rises with Rx_DATA=0xA5 and both error flags 0.
- Even parity, DATA_W=8, send 0x07 → TxD parity bit = 1; frame 4752 cycles; received PERROR=0. Inject a flipped parity bit via RxD → PERROR=1, data 0x07.
- Drive stop bit 0 on RxD with data 0x3C → entry 0x3C with FERROR=1; no new start until RxD returns high.
- FIFO_DEPTH=4: receive 5 frames (0x01..0x05) without reading → Rx_OVERRUN=1, reads return 0x01..0x04, then Rx_VALID=0; overrun clears on the first read.
- RxD low pulse of 5·DIV cycles → false start, no push. Deassert Rx_EN mid-frame → no push; the next full frame is received correctly.
- Assert reset mid-Tx-frame → TxD=1 and Tx_BUSY=0 immediately, FIFO empty; a new write after release transmits correctly.
